mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 198 +++++++++++++++++++
 tb/tb_mem_stage.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: memory stage of an in-order pipeline, one instruction at a time.
//
// Accepts one ExecInst from execute when idle, performs at most one data
// memory access and then raises a one-cycle retire pulse with writeback info.
//   clk_in / rst_in       clock, synchronous active-high reset
//   einst, in_valid       instruction from execute, taken when in_ready is high
//   in_ready              high only while idle
//   mem_addr/re/we/wdata  data memory request, driven only in the ISSUE cycle
//   mem_rdata             read data, valid MEM_LATENCY cycles after mem_re
//   done, wb_en, wb_dst, wb_data, next_pc, fault
//                         retire pulse and its writeback / fault information
//
// Handshake: einst is taken on a rising edge where in_valid && in_ready;
// in_valid may be dropped or einst changed freely at any other time.

package mem_stage_pkg;
    typedef enum logic [1:0] {
        IT_OP     = 2'd0,
        IT_LOAD   = 2'd1,
        IT_STORE  = 2'd2,
        IT_BRANCH = 2'd3
    } itype_t;

    // Size in bits [1:0], bit 2 marks an unsigned load.
    typedef enum logic [2:0] {
        MF_B  = 3'd0,
        MF_H  = 3'd1,
        MF_W  = 3'd2,
        MF_BU = 3'd4,
        MF_HU = 3'd5
    } mem_func_t;

    typedef struct packed {
        itype_t      itype;
        logic [4:0]  dst;
        logic        dst_valid;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] next_pc;
        mem_func_t   mem_func;
    } ExecInst;
endpackage

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  ExecInst     einst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_dst,
    output logic [31:0] wb_data,
    output logic [31:0] next_pc,
    output logic        fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        RETIRE = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    ExecInst     r_inst;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_fault;

    logic        w_accept;
    logic        w_is_mem;
    logic        w_misalign;
    logic [31:0] w_shift;
    logic [31:0] w_load_val;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_is_mem = (einst.itype == IT_LOAD) || (einst.itype == IT_STORE);

    // Alignment is judged on the incoming instruction so a misaligned
    // access can skip ISSUE entirely and never touch memory.
    always_comb begin
        w_misalign = 1'b0;
        case (einst.mem_func)
            MF_H, MF_HU: w_misalign = einst.addr[0];
            MF_W:        w_misalign = (einst.addr[1:0] != 2'b00);
            default:     w_misalign = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_is_mem && !w_misalign) ? ISSUE : RETIRE;
                end
            end
            ISSUE:   w_state_next = (r_inst.itype == IT_LOAD) ? WAIT : RETIRE;
            WAIT:    w_state_next = (r_cnt == 3'd1) ? RETIRE : WAIT;
            RETIRE:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // WAIT counter: loaded when entering WAIT; the cycle it reads 1 is the
    // cycle mem_rdata is valid, so the read word is captured on that edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_inst  <= '0;
            r_cnt   <= 3'd0;
            r_rdata <= 32'd0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_inst  <= einst;
                r_fault <= w_is_mem && w_misalign;
            end
            if (r_state == ISSUE) begin
                r_cnt <= 3'(MEM_LATENCY);
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    r_rdata <= mem_rdata;
                end
            end
        end
    end

    assign w_shift = r_rdata >> {r_inst.addr[1:0], 3'b000};

    always_comb begin
        w_load_val = w_shift;
        case (r_inst.mem_func)
            MF_B:    w_load_val = {{24{w_shift[7]}}, w_shift[7:0]};
            MF_BU:   w_load_val = {24'd0, w_shift[7:0]};
            MF_H:    w_load_val = {{16{w_shift[15]}}, w_shift[15:0]};
            MF_HU:   w_load_val = {16'd0, w_shift[15:0]};
            default: w_load_val = w_shift;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        mem_addr  = {r_inst.addr[31:2], 2'b00};
        mem_re    = 1'b0;
        mem_we    = 4'b0000;
        mem_wdata = r_inst.data;
        done      = (r_state == RETIRE);
        fault     = 1'b0;
        wb_en     = 1'b0;
        wb_dst    = r_inst.dst;
        wb_data   = (r_inst.itype == IT_LOAD) ? w_load_val : r_inst.data;
        next_pc   = r_inst.next_pc;

        case (r_inst.mem_func)
            MF_B, MF_BU: mem_wdata = {4{r_inst.data[7:0]}};
            MF_H, MF_HU: mem_wdata = {2{r_inst.data[15:0]}};
            default:     mem_wdata = r_inst.data;
        endcase

        if (r_state == ISSUE) begin
            if (r_inst.itype == IT_LOAD) begin
                mem_re = 1'b1;
            end else begin
                case (r_inst.mem_func)
                    MF_B, MF_BU: mem_we = 4'b0001 << r_inst.addr[1:0];
                    MF_H, MF_HU: mem_we = r_inst.addr[1] ? 4'b1100 : 4'b0011;
                    default:     mem_we = 4'b1111;
                endcase
            end
        end

        if (done) begin
            fault = r_fault;
            wb_en = r_inst.dst_valid && (r_inst.dst != 5'd0) && !r_fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table run against a MEM_LATENCY=2
// instance, a long-latency load on a MEM_LATENCY=5 instance, and reset
// sequences. Each bench-side memory model returns rd_word exactly
// MEM_LATENCY cycles after mem_re and garbage otherwise.

module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        ExecInst     inst;
        logic [31:0] rdata;
        int          exp_done;
        logic        exp_re;
        logic [3:0]  exp_we;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic        exp_fault;
        logic        exp_wb_en;
        logic [31:0] exp_wb_data;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    ExecInst     einst;
    logic        in_valid_a, in_valid_b;
    logic [31:0] rd_word;
    int          cur_sel;
    int          n_checks = 0;
    int          n_fail = 0;

    logic        in_ready_a, mem_re_a, done_a, wb_en_a, fault_a;
    logic [3:0]  mem_we_a;
    logic [4:0]  wb_dst_a;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a, wb_data_a, next_pc_a;
    logic        in_ready_b, mem_re_b, done_b, wb_en_b, fault_b;
    logic [3:0]  mem_we_b;
    logic [4:0]  wb_dst_b;
    logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b, wb_data_b, next_pc_b;

    logic        o_in_ready, o_mem_re, o_done, o_wb_en, o_fault;
    logic [3:0]  o_mem_we;
    logic [4:0]  o_wb_dst;
    logic [31:0] o_mem_addr, o_mem_wdata, o_wb_data, o_next_pc;

    logic [7:0]  re_hist_a = '0;
    logic [7:0]  re_hist_b = '0;

    always #5 clk = ~clk;

    mem_stage #(.MEM_LATENCY(2)) u_dut_a (
        .clk_in(clk), .rst_in(rst), .einst(einst), .in_valid(in_valid_a),
        .in_ready(in_ready_a), .mem_addr(mem_addr_a), .mem_re(mem_re_a),
        .mem_we(mem_we_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
        .done(done_a), .wb_en(wb_en_a), .wb_dst(wb_dst_a), .wb_data(wb_data_a),
        .next_pc(next_pc_a), .fault(fault_a)
    );

    mem_stage #(.MEM_LATENCY(5)) u_dut_b (
        .clk_in(clk), .rst_in(rst), .einst(einst), .in_valid(in_valid_b),
        .in_ready(in_ready_b), .mem_addr(mem_addr_b), .mem_re(mem_re_b),
        .mem_we(mem_we_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
        .done(done_b), .wb_en(wb_en_b), .wb_dst(wb_dst_b), .wb_data(wb_data_b),
        .next_pc(next_pc_b), .fault(fault_b)
    );

    // Memory models: re_hist[k] is high in the (k+1)-th cycle after mem_re.
    always @(posedge clk) begin
        re_hist_a <= {re_hist_a[6:0], mem_re_a};
        re_hist_b <= {re_hist_b[6:0], mem_re_b};
    end
    assign mem_rdata_a = re_hist_a[1] ? rd_word : 32'hDEAD_BEEF;
    assign mem_rdata_b = re_hist_b[4] ? rd_word : 32'hDEAD_BEEF;

    always_comb begin
        o_in_ready  = (cur_sel != 0) ? in_ready_b  : in_ready_a;
        o_mem_re    = (cur_sel != 0) ? mem_re_b    : mem_re_a;
        o_mem_we    = (cur_sel != 0) ? mem_we_b    : mem_we_a;
        o_mem_addr  = (cur_sel != 0) ? mem_addr_b  : mem_addr_a;
        o_mem_wdata = (cur_sel != 0) ? mem_wdata_b : mem_wdata_a;
        o_done      = (cur_sel != 0) ? done_b      : done_a;
        o_wb_en     = (cur_sel != 0) ? wb_en_b     : wb_en_a;
        o_wb_dst    = (cur_sel != 0) ? wb_dst_b    : wb_dst_a;
        o_wb_data   = (cur_sel != 0) ? wb_data_b   : wb_data_a;
        o_next_pc   = (cur_sel != 0) ? next_pc_b   : next_pc_a;
        o_fault     = (cur_sel != 0) ? fault_b     : fault_a;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic ExecInst mk(input itype_t it, input mem_func_t f,
                                   input logic [31:0] a, input logic [31:0] d,
                                   input logic [4:0] dst, input logic dv,
                                   input logic [31:0] npc);
        ExecInst e;
        e.itype     = it;
        e.mem_func  = f;
        e.addr      = a;
        e.data      = d;
        e.dst       = dst;
        e.dst_valid = dv;
        e.next_pc   = npc;
        return e;
    endfunction

    // Drives one instruction into the selected instance and follows it to
    // retirement, checking memory strobes and in_ready every cycle.
    task automatic run_vec(input int idx, input int sel, input vec_t v);
        bit         fin;
        logic       exp_re;
        logic [3:0] exp_we;
        fin = 1'b0;
        @(negedge clk);
        cur_sel = sel;
        rd_word = v.rdata;
        einst   = v.inst;
        #1;
        chk($sformatf("v%0d_ready_before", idx), o_in_ready, 1);
        if (sel != 0) in_valid_b = 1'b1;
        else          in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        einst = mk(IT_STORE, MF_W, $urandom, $urandom, 5'($urandom), 1'b1, $urandom);
        for (int c = 1; c <= 20 && !fin; c++) begin
            if (c > 1) begin
                @(posedge clk);
                #1;
            end
            exp_re = (c == 1) && v.exp_re;
            exp_we = (c == 1) ? v.exp_we : 4'b0000;
            chk($sformatf("v%0d_c%0d_mem_re", idx, c), o_mem_re, exp_re);
            chk($sformatf("v%0d_c%0d_mem_we", idx, c), o_mem_we, exp_we);
            chk($sformatf("v%0d_c%0d_in_ready", idx, c), o_in_ready, 0);
            if (c == 1 && (v.exp_re || v.exp_we != 4'b0000)) begin
                chk($sformatf("v%0d_mem_addr", idx), o_mem_addr, v.exp_addr);
                if (v.exp_we != 4'b0000)
                    chk($sformatf("v%0d_mem_wdata", idx), o_mem_wdata, v.exp_wdata);
            end
            if (o_done) begin
                fin = 1'b1;
                chk($sformatf("v%0d_done_cycle", idx), c, v.exp_done);
                chk($sformatf("v%0d_fault", idx), o_fault, v.exp_fault);
                chk($sformatf("v%0d_wb_en", idx), o_wb_en, v.exp_wb_en);
                if (!v.exp_fault)
                    chk($sformatf("v%0d_wb_data", idx), o_wb_data, v.exp_wb_data);
                if (v.exp_wb_en)
                    chk($sformatf("v%0d_wb_dst", idx), o_wb_dst, v.inst.dst);
                chk($sformatf("v%0d_next_pc", idx), o_next_pc, v.inst.next_pc);
            end else begin
                chk($sformatf("v%0d_c%0d_flags_quiet", idx, c), {o_fault, o_wb_en}, 0);
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL v%0d_timeout: got no done expected done at cycle %0d", idx, v.exp_done);
        end else begin
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready_after", idx), o_in_ready, 1);
            chk($sformatf("v%0d_done_one_cycle", idx), o_done, 0);
        end
    endtask

    vec_t vecs[13];
    vec_t lhu_vec;
    bit   saw_done;

    initial begin
        vecs[0]  = '{mk(IT_OP,    MF_W,  32'h0000_0000, 32'h0000_1234, 5'd5, 1'b1, 32'h0000_1004),
                     32'h0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000_1234};
        vecs[1]  = '{mk(IT_LOAD,  MF_B,  32'h0000_0103, 32'h0, 5'd7, 1'b1, 32'h0000_2000),
                     32'h80FF_FFFF, 4, 1'b1, 4'b0000, 32'h0000_0100, 32'h0, 1'b0, 1'b1, 32'hFFFF_FF80};
        vecs[2]  = '{mk(IT_STORE, MF_H,  32'h0000_0202, 32'h0000_ABCD, 5'd0, 1'b0, 32'h0000_3000),
                     32'h0, 2, 1'b0, 4'b1100, 32'h0000_0200, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0000_ABCD};
        vecs[3]  = '{mk(IT_LOAD,  MF_W,  32'h0000_0301, 32'h0, 5'd9, 1'b1, 32'h0000_4000),
                     32'h0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[4]  = '{mk(IT_STORE, MF_B,  32'h0000_0041, 32'h0000_005A, 5'd0, 1'b0, 32'h0000_5000),
                     32'h0, 2, 1'b0, 4'b0010, 32'h0000_0040, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0000_005A};
        vecs[5]  = '{mk(IT_STORE, MF_W,  32'hFFFF_FFFC, 32'hCAFE_F00D, 5'd0, 1'b0, 32'hFFFF_FFFC),
                     32'h0, 2, 1'b0, 4'b1111, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D};
        vecs[6]  = '{mk(IT_LOAD,  MF_BU, 32'h0000_0502, 32'h0, 5'd10, 1'b1, 32'h0000_6000),
                     32'h12F0_3456, 4, 1'b1, 4'b0000, 32'h0000_0500, 32'h0, 1'b0, 1'b1, 32'h0000_00F0};
        vecs[7]  = '{mk(IT_LOAD,  MF_H,  32'h0000_0600, 32'h0, 5'd11, 1'b1, 32'h0000_7000),
                     32'h1234_8765, 4, 1'b1, 4'b0000, 32'h0000_0600, 32'h0, 1'b0, 1'b1, 32'hFFFF_8765};
        vecs[8]  = '{mk(IT_LOAD,  MF_W,  32'hFFFF_FFFC, 32'h0, 5'd0, 1'b1, 32'h0000_8000),
                     32'h89AB_CDEF, 4, 1'b1, 4'b0000, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0, 32'h89AB_CDEF};
        vecs[9]  = '{mk(IT_STORE, MF_H,  32'h0000_0703, 32'h0000_1111, 5'd0, 1'b0, 32'h0000_9000),
                     32'h0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[10] = '{mk(IT_LOAD,  MF_HU, 32'h0000_0801, 32'h0, 5'd12, 1'b1, 32'h0000_A000),
                     32'h0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0};
        vecs[11] = '{mk(IT_OP,    MF_W,  32'h0, 32'h7777_0001, 5'd3, 1'b0, 32'h0000_B000),
                     32'h0, 1, 1'b0, 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 32'h7777_0001};
        vecs[12] = '{mk(IT_STORE, MF_H,  32'h0000_0204, 32'h1234_BEEF, 5'd0, 1'b0, 32'h0000_C000),
                     32'h0, 2, 1'b0, 4'b0011, 32'h0000_0204, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h1234_BEEF};
        lhu_vec  = '{mk(IT_LOAD,  MF_HU, 32'h0000_0902, 32'h0, 5'd13, 1'b1, 32'h0000_D000),
                     32'h8001_0000, 7, 1'b1, 4'b0000, 32'h0000_0900, 32'h0, 1'b0, 1'b1, 32'h0000_8001};

        // Reset state
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        einst      = '0;
        rd_word    = 32'h0;
        cur_sel    = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset_in_ready_a", in_ready_a, 1);
        chk("reset_in_ready_b", in_ready_b, 1);
        chk("reset_done", done_a, 0);
        chk("reset_wb_en", wb_en_a, 0);
        chk("reset_fault", fault_a, 0);
        chk("reset_mem_re", mem_re_a, 0);
        chk("reset_mem_we", mem_we_a, 0);

        for (int i = 0; i < 13; i++) begin
            run_vec(i, 0, vecs[i]);
        end
        run_vec(13, 1, lhu_vec);

        // Reset sampled at edge T+2 of a load abandons it.
        @(negedge clk);
        cur_sel    = 0;
        rd_word    = 32'h1357_9BDF;
        einst      = vecs[1].inst;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        chk("rstmid_mem_re", mem_re_a, 1);
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b1;
        einst      = vecs[0].inst;
        in_valid_a = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_done_in_reset", done_a, 0);
        chk("rstmid_in_ready_in_reset", in_ready_a, 1);
        @(negedge clk);
        rst        = 1'b0;
        in_valid_a = 1'b0;
        chk("rstmid_ready_after_deassert", in_ready_a, 1);
        saw_done = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (done_a || mem_re_a || wb_en_a) saw_done = 1'b1;
        end
        chk("rstmid_no_done", saw_done, 0);

        // in_valid during a reset cycle while idle is not accepted.
        @(negedge clk);
        rst        = 1'b1;
        einst      = vecs[0].inst;
        in_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        in_valid_a = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            if (done_a || !in_ready_a) saw_done = 1'b1;
        end
        chk("rstcycle_not_accepted", saw_done, 0);

        // The stage still works after those resets.
        run_vec(14, 0, vecs[7]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no summary by 100000 expected earlier finish");
        $fatal(1, "watchdog expired");
    end

endmodule
